// File: rtl/cbm_synapse_accumulator_if.sv
// Handshake bundle between the neuron core and the synapse accumulator.
// Ports: state stream (BS), accumulation stream (AS), weight write channel.
interface cbm_synapse_accumulator_if #(
    parameter int NI = 1,
    parameter int NO = 1,
    parameter int NH = 4,
    parameter int WS = 8
);
    localparam int NS = NI + NO + NH;
    localparam int WA = $clog2(NS) + WS;
    localparam int WW = $clog2(NH * NS);

    logic                 iValid_BS;
    logic                 oReady_BS;
    logic [NH*3-1:0]      iData_BS;
    logic [NI+NO-1:0]     iData_X;
    logic                 oValid_AS;
    logic                 iReady_AS;
    logic [NH*WA-1:0]     oData_AS;
    logic                 iWValid;
    logic                 oWReady;
    logic [WW-1:0]        iWAddr;
    logic [WS-1:0]        iWData;

    modport slave (
        input  iValid_BS, iData_BS, iData_X, iReady_AS,
        input  iWValid, iWAddr, iWData,
        output oReady_BS, oValid_AS, oData_AS, oWReady
    );

    modport master (
        output iValid_BS, iData_BS, iData_X, iReady_AS,
        output iWValid, iWAddr, iWData,
        input  oReady_BS, oValid_AS, oData_AS, oWReady
    );
endinterface

// File: rtl/cbm_synapse_accumulator.sv
// Signed synapse accumulator: acc[i] = sum_j (s[j] ? +w[i][j] : -w[i][j]).
// Ports: iCLK, iRST_N (async, active-low), bus (slave modport): state vector
// in (iValid_BS/oReady_BS/iData_BS/iData_X), lane sums out
// (oValid_AS/iReady_AS/oData_AS), weight writes (iWValid/oWReady/iWAddr/iWData).
// Option: CBM_SYNAPSE_DUAL_LANE_EN adds two sources per ACCUM cycle.
module cbm_synapse_accumulator #(
    parameter int NI = 1,
    parameter int NO = 1,
    parameter int NH = 4,
    parameter int WS = 8
) (
    input logic iCLK,
    input logic iRST_N,
    cbm_synapse_accumulator_if.slave bus
);
    localparam int NS = NI + NO + NH;
    localparam int WA = $clog2(NS) + WS;
    localparam int WW = $clog2(NH * NS);
    localparam int SW = $clog2(NS);
    localparam int NX = NI + NO;

    localparam logic [WS-1:0] WMIN  = {1'b1, {(WS-1){1'b0}}};
    localparam logic [WS-1:0] WMIN1 = {1'b1, {(WS-2){1'b0}}, 1'b1};

`ifdef CBM_SYNAPSE_DUAL_LANE_EN
    localparam logic [SW:0]   NSW  = (SW+1)'(NS);
    localparam logic [SW-1:0] STEP = SW'(2);
`else
    localparam logic [SW-1:0] STEP = SW'(1);
`endif

    typedef enum logic [1:0] {GET, ACCUM, PUT} state_t;

    state_t state, state_nxt;

    logic signed [WS-1:0] w [NH*NS];
    logic [NS-1:0]        src;
    logic [SW-1:0]        j;
    logic signed [WA-1:0] acc [NH];
    logic signed [WA-1:0] acc_nxt [NH];
    logic signed [WA-1:0] res [NH];
    logic                 last;
    logic                 take_bs;
    logic                 wr_hit;
    logic                 unused_bs;

    // Only the estt field of the core state is a source.
    assign unused_bs = ^bus.iData_BS[NH*3-1:NH];

    function automatic logic signed [WA-1:0] term(
        input logic s,
        input logic signed [WS-1:0] wv
    );
        logic signed [WA-1:0] e;
        e = {{(WA-WS){wv[WS-1]}}, wv};
        return s ? e : -e;
    endfunction

    function automatic logic [WW-1:0] waddr(input int i, input logic [SW:0] jj);
        return WW'(i * NS) + WW'(jj);
    endfunction

    always_comb begin
        logic [SW:0] j0;
`ifdef CBM_SYNAPSE_DUAL_LANE_EN
        logic [SW:0] j1;
`endif
        j0 = {1'b0, j};
`ifdef CBM_SYNAPSE_DUAL_LANE_EN
        j1 = j0 + (SW+1)'(1);
        last = (j0 + (SW+1)'(2)) >= NSW;
`else
        last = (j == SW'(NS - 1));
`endif
        for (int i = 0; i < NH; i++) begin
            acc_nxt[i] = acc[i] + term(src[j], w[waddr(i, j0)]);
`ifdef CBM_SYNAPSE_DUAL_LANE_EN
            // Odd source count: the final pair has no second term.
            if (j1 < NSW)
                acc_nxt[i] = acc_nxt[i] + term(src[j1[SW-1:0]], w[waddr(i, j1)]);
`endif
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            state <= GET;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.oReady_BS = 1'b0;
        bus.oWReady   = 1'b0;
        bus.oValid_AS = 1'b0;
        unique case (state)
            GET: begin
                bus.oReady_BS = 1'b1;
                bus.oWReady   = 1'b1;
                if (bus.iValid_BS)
                    state_nxt = ACCUM;
            end
            ACCUM: begin
                if (last)
                    state_nxt = PUT;
            end
            PUT: begin
                bus.oValid_AS = 1'b1;
                if (bus.iReady_AS)
                    state_nxt = GET;
            end
            default: state_nxt = GET;
        endcase
    end

    assign take_bs = bus.iValid_BS & bus.oReady_BS;
    assign wr_hit  = bus.iWValid & bus.oWReady &
                     ({1'b0, bus.iWAddr} < (WW+1)'(NH * NS));

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            w   <= '{default: '0};
            acc <= '{default: '0};
            res <= '{default: '0};
            src <= '0;
            j   <= '0;
        end else begin
            // Most-negative weight is pulled in by one so |acc| fits WA bits.
            if (wr_hit)
                w[bus.iWAddr] <= (bus.iWData == WMIN) ? WMIN1 : bus.iWData;
            if (take_bs) begin
                src <= {bus.iData_BS[NH-1:0], bus.iData_X[NX-1:0]};
                j   <= '0;
                acc <= '{default: '0};
            end else if (state == ACCUM) begin
                acc <= acc_nxt;
                j   <= j + STEP;
                if (last)
                    res <= acc_nxt;
            end
        end
    end

    always_comb begin
        bus.oData_AS = '0;
        for (int i = 0; i < NH; i++)
            bus.oData_AS[i*WA +: WA] = res[i];
    end
endmodule
